// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: 8N1 UART receiver, LSB first, mid-bit sampling.
// Synchronises the RX line, validates the start bit, samples 8 data bits
// and the stop bit, and emits a one-cycle done or frame-error pulse.
module uart_rx_deframer #(
    parameter int unsigned KBAUD = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_DataBit,
    output logic [7:0] out_DataByte,
    output logic       out_RxDone,
    output logic       out_FrameErr
);

    localparam int unsigned H  = KBAUD / 2;
    localparam int unsigned CW = $clog2(KBAUD);

    typedef enum logic [2:0] {
        WAIT_HIGH = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        STOP      = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            sync1;
    logic            rx_s;
    logic [1:0]      fill;
    logic            fill_done;

    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic [2:0]      bit_idx;
    logic [2:0]      bit_idx_nxt;
    logic [7:0]      shreg;
    logic [7:0]      shreg_nxt;
    logic [7:0]      byte_nxt;
    logic            done_nxt;
    logic            err_nxt;

    logic            half_hit;
    logic            bit_hit;

    // Two-flop synchroniser; the fill counter marks when rx_s reflects the
    // real line again, so the reset value of the flops is never mistaken
    // for an idle-high line after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
            fill  <= 2'd0;
        end else begin
            sync1 <= in_DataBit;
            rx_s  <= sync1;
            if (!fill[1]) begin
                fill <= fill + 2'd1;
            end
        end
    end

    assign fill_done = fill[1];
    assign half_hit  = (cnt == CW'(H - 1));
    assign bit_hit   = (cnt == CW'(KBAUD - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= WAIT_HIGH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_HIGH: begin
                if (rx_s && fill_done) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (half_hit) begin
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_hit && (bit_idx == 3'd7)) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_hit) begin
                    state_nxt = rx_s ? IDLE : WAIT_HIGH;
                end
            end
            default: state_nxt = WAIT_HIGH;
        endcase
    end

    // Datapath and output next values: counter runs from each sample point,
    // so a sample lands every KBAUD cycles after the half-bit start check.
    always_comb begin
        cnt_nxt     = cnt + CW'(1);
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        byte_nxt    = out_DataByte;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            WAIT_HIGH, IDLE: begin
                cnt_nxt     = '0;
                bit_idx_nxt = 3'd0;
            end
            START: begin
                if (half_hit) begin
                    cnt_nxt = '0;
                end
            end
            DATA: begin
                if (bit_hit) begin
                    cnt_nxt     = '0;
                    shreg_nxt   = {rx_s, shreg[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (bit_hit) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        byte_nxt = shreg;
                        done_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            default: begin
                cnt_nxt     = '0;
                bit_idx_nxt = 3'd0;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt          <= '0;
            bit_idx      <= 3'd0;
            shreg        <= 8'h00;
            out_DataByte <= 8'h00;
            out_RxDone   <= 1'b0;
            out_FrameErr <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            bit_idx      <= bit_idx_nxt;
            shreg        <= shreg_nxt;
            out_DataByte <= byte_nxt;
            out_RxDone   <= done_nxt;
            out_FrameErr <= err_nxt;
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Testbench for uart_rx_deframer: a KBAUD=5 instance for directed frames
// and a KBAUD=16 instance fed by a behavioural transmitter with random bytes.
module tb_uart_rx_deframer;

    logic       clk = 1'b0;
    logic       rst;
    logic       line5;
    logic       line16;
    logic [7:0] byte5;
    logic [7:0] byte16;
    logic       done5;
    logic       done16;
    logic       err5;
    logic       err16;

    always #5 clk = ~clk;

    uart_rx_deframer #(.KBAUD(5)) u5 (
        .clk          (clk),
        .rst          (rst),
        .in_DataBit   (line5),
        .out_DataByte (byte5),
        .out_RxDone   (done5),
        .out_FrameErr (err5)
    );

    uart_rx_deframer #(.KBAUD(16)) u16 (
        .clk          (clk),
        .rst          (rst),
        .in_DataBit   (line16),
        .out_DataByte (byte16),
        .out_RxDone   (done16),
        .out_FrameErr (err16)
    );

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       q5[$];
    exp_t       q16[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [7:0] last_good [2];
    logic       prev5  = 1'b0;
    logic       prev16 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    // Pops the scoreboard whenever an instance presents a pulse.
    task automatic mon(input int inst, input logic d, input logic e,
                       input logic [7:0] dat, input logic prev);
        exp_t x;
        int   qs;
        if (d || e) begin
            chk("pulse_exclusive", int'(d & e), 0);
            chk("pulse_back_to_back", int'(prev), 0);
            qs = (inst == 0) ? q5.size() : q16.size();
            if (qs == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                if (inst == 0) x = q5.pop_front();
                else           x = q16.pop_front();
                chk("pulse_kind_err", int'(e), int'(x.is_err));
                chk("pulse_cycle", cyc, x.cyc);
                chk("pulse_byte", int'(dat), int'(x.data));
            end
        end
    endtask

    // Monitors sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        mon(0, done5, err5, byte5, prev5);
        mon(1, done16, err16, byte16, prev16);
        prev5  <= done5 | err5;
        prev16 <= done16 | err16;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int inst, input logic v);
        if (inst == 0) line5 = v;
        else           line16 = v;
    endtask

    // Behavioural transmitter plus reference model: a frame starting at
    // cycle c produces its pulse 2 sync cycles + half bit + 9 bits + 1 later.
    task automatic send(input int inst, input logic [7:0] b, input logic stop);
        int   k;
        int   c;
        exp_t e;
        logic v;
        k = (inst == 0) ? 5 : 16;
        c = cyc;
        e.is_err = !stop;
        e.cyc    = c + 2 + k / 2 + 9 * k + 1;
        if (stop) begin
            e.data          = b;
            last_good[inst] = b;
        end else begin
            e.data = last_good[inst];
        end
        if (inst == 0) q5.push_back(e);
        else           q16.push_back(e);
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      v = 1'b0;
            else if (i == 9) v = stop;
            else             v = b[i-1];
            set_line(inst, v);
            idle(k);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [7:0] pat;
        rst          = 1'b0;
        line5        = 1'b1;
        line16       = 1'b1;
        last_good[0] = 8'h00;
        last_good[1] = 8'h00;
        idle(3);
        chk("reset_byte5", int'(byte5), 0);
        chk("reset_done5", int'(done5), 0);
        chk("reset_err5", int'(err5), 0);
        chk("reset_byte16", int'(byte16), 0);
        rst = 1'b1;
        idle(10);

        // Good frame 0xA5.
        send(0, 8'hA5, 1'b1);
        idle(5);
        chk("t1_byte_held", int'(byte5), 'hA5);

        // One-cycle glitch must not start a frame.
        set_line(0, 1'b0);
        idle(1);
        set_line(0, 1'b1);
        idle(20);
        chk("t2_byte_unchanged", int'(byte5), 'hA5);

        // Bad stop bit, then a good frame.
        send(0, 8'h3C, 1'b0);
        set_line(0, 1'b1);
        idle(5);
        chk("t3_byte_kept", int'(byte5), 'hA5);
        send(0, 8'h81, 1'b1);
        idle(5);
        chk("t3_next_good", int'(byte5), 'h81);

        // Back-to-back frames.
        send(0, 8'h00, 1'b1);
        send(0, 8'hFF, 1'b1);
        idle(5);
        chk("t4_last_byte", int'(byte5), 'hFF);

        // Reset during data bit 3 of 0x55, line then held low.
        pat = 8'h55;
        set_line(0, 1'b0);
        idle(5);
        for (int i = 0; i < 3; i++) begin
            set_line(0, pat[i]);
            idle(5);
        end
        set_line(0, pat[3]);
        idle(2);
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        last_good[0] = 8'h00;
        last_good[1] = 8'h00;
        set_line(0, 1'b0);
        chk("t5_byte_reset", int'(byte5), 0);
        chk("t5_byte16_reset", int'(byte16), 0);
        idle(150);
        chk("t5_byte_low_line", int'(byte5), 0);
        set_line(0, 1'b1);
        idle(20);
        send(0, 8'h6B, 1'b1);
        idle(5);
        chk("t5_after_recover", int'(byte5), 'h6B);

        // Random stream at KBAUD=16 with small random gaps.
        for (int n = 0; n < 256; n++) begin
            b = 8'($urandom);
            send(1, b, 1'b1);
            idle(int'($urandom_range(0, 3)));
        end
        idle(40);
        chk("t6_last_byte", int'(byte16), int'(last_good[1]));

        chk("q5_drained", q5.size(), 0);
        chk("q16_drained", q16.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
